writeback_arbiter: RTL and testbench
====================================

# writeback_arbiter

Merges execute-stage results and load responses into the single write port of the integer register file and drives its `rd_index`/`rd_in`/`rd_we` inputs from registered outputs. Load results are buffered in a small FIFO whenever an execute result wins the port. A per-register busy scoreboard tracks outstanding loads so decode can stall on load-use hazards. Sits between execute/memory and the register file.

## Interface
- `FIFO_DEPTH`, 2, load-result buffer entries; power of two, ≥2
- `clk`  in  1  core clock, posedge
- `rst_n`  in  1  asynchronous, active-low reset
- `ex_valid`  in  1  execute result valid this cycle; no backpressure
- `ex_rd`  in  5  execute destination register
- `ex_data`  in  32 (`uint32_t`)  execute result
- `mem_valid`  in  1  load response valid
- `mem_ready`  out  1  load response accepted (`!fifo_full`, 0 while `rst_n` low)
- `mem_rd`  in  5  load destination register
- `mem_data`  in  32  load data
- `ld_issue`  in  1  load issued to memory this cycle
- `ld_issue_rd`  in  5  destination of issued load
- `rs1_query`, `rs2_query`  in  5 each  decode source indices
- `rs1_busy`, `rs2_busy`  out  1 each  combinational: queried register has an outstanding load
- `rf_we`  out  1  register-file write enable
- `rf_rd_index`  out  5  register-file write index
- `rf_rd_data`  out  32  register-file write data

## Operation
- Handshake: load accepted when `mem_valid && mem_ready` at posedge.
- Per posedge, select one write source: (1) `ex_valid` → ex result; else (2) FIFO non-empty → FIFO head, popped; else (3) accepted load with FIFO empty → bypass directly; else no write.
- An accepted load not selected is pushed to FIFO (tail). Push and pop in same cycle allowed, including when full (pop frees slot; `mem_ready` is still computed from the pre-edge full flag).
- Selected write with rd = 0: `rf_we` = 0, index/data still updated; load still retires (busy logic unaffected since x0 never set busy).
- Scoreboard: 32 busy bits. `ld_issue` with rd≠0 sets bit. A load write to the register file clears bit at the same edge `rf_we` rises. Set and clear of the same register in one cycle: set wins.
- `rsN_busy` = busy[`rsN_query`]; always 0 for index 0.
- Protocol violations, covered by assertions not logic: `ex_valid` with `ex_rd` busy; `ld_issue` to an already-busy rd; `mem_valid` for a rd not busy.
- Starvation: continuous `ex_valid` starves loads; FIFO fills and `mem_ready` drops. No fairness mechanism; decode stalls on busy break the loop.

## Timing
- Reset (async assert, sync deassert to `clk`): `rf_we`=0, `rf_rd_index`=0, `rf_rd_data`=0, busy all 0, FIFO empty, `mem_ready`=0 while low, 1 first cycle after.
- Reset mid-operation discards FIFO contents and busy bits; no partial write emitted.
- Latency: ex result at cycle N → `rf_we` high in cycle N+1; bypassed load same. Buffered load: one cycle after the last preceding ex write.
- Outputs change only on posedge; register file captures on negedge of the same cycle, so data is stable half a cycle before capture.
- `rf_we` is a one-cycle pulse per write; back-to-back writes allowed every cycle.

## Structure
- `FIFO_DEPTH` default and a `wb_entry_t` struct (`rd` 5 bits, `data` `uint32_t`) go in `Types`.
- One sub-module: `wb_fifo` (parameterised sync FIFO, push/pop/full/empty, pointer wrap at `FIFO_DEPTH`, one extra pointer bit for full/empty).
- Scoreboard and arbitration live in `writeback_arbiter` itself.

## Test plan
- After reset, `ex_valid`, rd=5, data 0xDEADBEEF → next cycle `rf_we`=1, index 5, data 0xDEADBEEF; following cycle `rf_we`=0.
- `ld_issue` rd=7 → `rs1_busy`=1 for query 7 next cycle; response 0x12345678 with no ex → write to x7 one cycle later, busy clears same edge.
- ex rd=3 and load rd=4 same cycle → x3 written first, x4 next cycle from FIFO.
- `ex_valid` held 4 cycles while 3 loads arrive (depth 2) → third load sees `mem_ready`=0 until FIFO pops; all loads written in order after ex stops.
- ex write to rd=0 → `rf_we` stays 0; `ld_issue` rd=0 → busy never set.
- Assert `rst_n` low with 2 buffered loads → outputs and busy zero immediately; no writes after release.

Source files
------------

// File: rtl/writeback_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | writeback_arbiter_pkg : shared types for the writeback arbiter     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package writeback_arbiter_pkg;

   localparam int unsigned c_FIFO_DEPTH = 2;

   typedef logic [31:0] uint32_t;
   typedef logic [4:0]  reg_idx_t;

   typedef struct packed {
      reg_idx_t rd;
      uint32_t  data;
   } wb_entry_t;

   typedef enum logic [1:0] {
      SRC_NONE   = 2'd0,
      SRC_EX     = 2'd1,
      SRC_FIFO   = 2'd2,
      SRC_BYPASS = 2'd3
   } wb_src_e;

   function automatic logic [31:0] reg_mask(input reg_idx_t idx);
      logic [31:0] m;
      m      = '0;
      m[idx] = 1'b1;
      return m;
   endfunction

endpackage
`default_nettype wire

// File: rtl/writeback_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | writeback_arbiter_if : execute/memory/decode/register-file bundle  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface writeback_arbiter_if;
   import writeback_arbiter_pkg::*;

   logic     ex_valid;
   reg_idx_t ex_rd;
   uint32_t  ex_data;

   logic     mem_valid;
   logic     mem_ready;
   reg_idx_t mem_rd;
   uint32_t  mem_data;

   logic     ld_issue;
   reg_idx_t ld_issue_rd;

   reg_idx_t rs1_query;
   reg_idx_t rs2_query;
   logic     rs1_busy;
   logic     rs2_busy;

   logic     rf_we;
   reg_idx_t rf_rd_index;
   uint32_t  rf_rd_data;

   modport master (
      output ex_valid, ex_rd, ex_data,
      output mem_valid, mem_rd, mem_data,
      input  mem_ready,
      output ld_issue, ld_issue_rd,
      output rs1_query, rs2_query,
      input  rs1_busy, rs2_busy,
      input  rf_we, rf_rd_index, rf_rd_data
   );

   modport slave (
      input  ex_valid, ex_rd, ex_data,
      input  mem_valid, mem_rd, mem_data,
      output mem_ready,
      input  ld_issue, ld_issue_rd,
      input  rs1_query, rs2_query,
      output rs1_busy, rs2_busy,
      output rf_we, rf_rd_index, rf_rd_data
   );

endinterface
`default_nettype wire

// File: rtl/writeback_arbiter_wb_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | wb_fifo : synchronous FIFO of pending load results                 |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module wb_fifo
   import writeback_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH = c_FIFO_DEPTH
) (
   input  wire logic      clk,
   input  wire logic      rst_n,
   input  wire logic      i_push,
   input  wire wb_entry_t i_push_data,
   input  wire logic      i_pop,
   output wb_entry_t      o_pop_data,
   output logic           o_full,
   output logic           o_empty
);

   localparam int unsigned c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   wb_entry_t       r_mem [DEPTH];
   logic [c_AW:0]   r_wr_ptr;
   logic [c_AW:0]   r_rd_ptr;
   logic            w_do_push;
   logic            w_do_pop;

   // Extra MSB distinguishes full from empty when the index bits match.
   assign o_empty    = (r_wr_ptr == r_rd_ptr);
   assign o_full     = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                       (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
   assign o_pop_data = r_mem[r_rd_ptr[c_AW-1:0]];

   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= i_push_data;
   end

endmodule
`default_nettype wire

// File: rtl/writeback_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | writeback_arbiter : register-file write port arbiter + scoreboard  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module writeback_arbiter
   import writeback_arbiter_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = c_FIFO_DEPTH
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   writeback_arbiter_if.slave bus
);

   logic        w_fifo_full;
   logic        w_fifo_empty;
   wb_entry_t   w_fifo_head;
   logic        w_accept;
   logic        w_push;
   logic        w_pop;
   logic        w_load_wr;
   wb_src_e     w_src;
   wb_entry_t   w_sel;
   logic [31:0] w_busy_nxt;

   logic [31:0] r_busy;
   logic        r_we;
   reg_idx_t    r_index;
   uint32_t     r_data;

   // Ready follows the pre-edge full flag, so a pop never admits a load early.
   assign bus.mem_ready = rst_n && !w_fifo_full;
   assign w_accept      = bus.mem_valid && bus.mem_ready;

   always_comb begin
      w_src = SRC_NONE;
      w_sel = '0;
      if (bus.ex_valid) begin
         w_src = SRC_EX;
         w_sel = '{rd: bus.ex_rd, data: bus.ex_data};
      end else if (!w_fifo_empty) begin
         w_src = SRC_FIFO;
         w_sel = w_fifo_head;
      end else if (w_accept) begin
         w_src = SRC_BYPASS;
         w_sel = '{rd: bus.mem_rd, data: bus.mem_data};
      end
   end

   assign w_pop     = (w_src == SRC_FIFO);
   assign w_push    = w_accept && (w_src != SRC_BYPASS);
   assign w_load_wr = (w_src == SRC_FIFO) || (w_src == SRC_BYPASS);

   wb_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_push      (w_push),
      .i_push_data ('{rd: bus.mem_rd, data: bus.mem_data}),
      .i_pop       (w_pop),
      .o_pop_data  (w_fifo_head),
      .o_full      (w_fifo_full),
      .o_empty     (w_fifo_empty)
   );

   // Clear first, then set, so an issue to a retiring register keeps it busy.
   always_comb begin
      w_busy_nxt = r_busy;
      if (w_load_wr)
         w_busy_nxt = w_busy_nxt & ~reg_mask(w_sel.rd);
      if (bus.ld_issue && (bus.ld_issue_rd != '0))
         w_busy_nxt = w_busy_nxt | reg_mask(bus.ld_issue_rd);
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy  <= '0;
         r_we    <= 1'b0;
         r_index <= '0;
         r_data  <= '0;
      end else begin
         r_busy <= w_busy_nxt;
         r_we   <= (w_src != SRC_NONE) && (w_sel.rd != '0);
         if (w_src != SRC_NONE) begin
            r_index <= w_sel.rd;
            r_data  <= w_sel.data;
         end
      end
   end

   assign bus.rf_we       = r_we;
   assign bus.rf_rd_index = r_index;
   assign bus.rf_rd_data  = r_data;
   assign bus.rs1_busy    = (bus.rs1_query != '0) && r_busy[bus.rs1_query];
   assign bus.rs2_busy    = (bus.rs2_query != '0) && r_busy[bus.rs2_query];

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (!(bus.ex_valid && r_busy[bus.ex_rd]))
            else $error("protocol violation: ex write to busy x%0d", bus.ex_rd);
         assert (!(bus.ld_issue && r_busy[bus.ld_issue_rd] &&
                   !(w_load_wr && (w_sel.rd == bus.ld_issue_rd))))
            else $error("protocol violation: load issued to busy x%0d", bus.ld_issue_rd);
         assert (!(bus.mem_valid && (bus.mem_rd != '0) && !r_busy[bus.mem_rd]))
            else $error("protocol violation: load response for idle x%0d", bus.mem_rd);
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_writeback_arbiter : directed + random bench with queue model    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_writeback_arbiter;
   import writeback_arbiter_pkg::*;

   localparam int DEPTH = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   writeback_arbiter_if bus ();

   writeback_arbiter #(
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference state: buffered loads, busy set, expected port outputs.
   logic [4:0]  q_rd [$];
   logic [31:0] q_dt [$];
   logic [4:0]  pending [$];
   bit          mbusy [32];
   logic        m_we;
   logic [4:0]  m_idx;
   logic [31:0] m_data;
   bit          m_accept;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q_rd.delete();
      q_dt.delete();
      pending.delete();
      foreach (mbusy[i]) mbusy[i] = 1'b0;
      m_we     = 1'b0;
      m_idx    = '0;
      m_data   = '0;
      m_accept = 1'b0;
   endtask

   task automatic idle();
      bus.ex_valid    = 1'b0;
      bus.ex_rd       = '0;
      bus.ex_data     = '0;
      bus.mem_valid   = 1'b0;
      bus.mem_rd      = '0;
      bus.mem_data    = '0;
      bus.ld_issue    = 1'b0;
      bus.ld_issue_rd = '0;
   endtask

   task automatic present_mem();
      if (!bus.mem_valid && pending.size() > 0) begin
         bus.mem_valid = 1'b1;
         bus.mem_rd    = pending[0];
         bus.mem_data  = $urandom;
      end
   endtask

   // One clock: check combinational outputs, advance the model, check registers.
   task automatic step();
      bit          rdy, acc, wr, ldw, byp;
      logic [4:0]  wr_rd;
      logic [31:0] wr_d;
      #3;
      rdy = (rst_n === 1'b1) && (q_rd.size() < DEPTH);
      chk("mem_ready", bus.mem_ready, rdy);
      chk("rs1_busy", bus.rs1_busy, mbusy[bus.rs1_query]);
      chk("rs2_busy", bus.rs2_busy, mbusy[bus.rs2_query]);
      acc = bus.mem_valid && rdy;
      wr = 0; ldw = 0; byp = 0; wr_rd = '0; wr_d = '0;
      if (bus.ex_valid) begin
         wr = 1; wr_rd = bus.ex_rd; wr_d = bus.ex_data;
      end else if (q_rd.size() > 0) begin
         wr = 1; ldw = 1; wr_rd = q_rd.pop_front(); wr_d = q_dt.pop_front();
      end else if (acc) begin
         wr = 1; ldw = 1; byp = 1; wr_rd = bus.mem_rd; wr_d = bus.mem_data;
      end
      if (acc && !byp) begin
         q_rd.push_back(bus.mem_rd);
         q_dt.push_back(bus.mem_data);
      end
      if (ldw) mbusy[wr_rd] = 1'b0;
      if (bus.ld_issue && bus.ld_issue_rd != 0) mbusy[bus.ld_issue_rd] = 1'b1;
      m_we = wr && (wr_rd != 0);
      if (wr) begin
         m_idx  = wr_rd;
         m_data = wr_d;
      end
      m_accept = acc;
      @(posedge clk);
      #1;
      chk("rf_we", bus.rf_we, m_we);
      chk("rf_rd_index", bus.rf_rd_index, m_idx);
      chk("rf_rd_data", bus.rf_rd_data, m_data);
      if (bus.ld_issue && bus.ld_issue_rd != 0) pending.push_back(bus.ld_issue_rd);
      if (m_accept) begin
         void'(pending.pop_front());
         bus.mem_valid = 1'b0;
      end
   endtask

   task automatic issue(input logic [4:0] rd);
      idle();
      bus.ld_issue    = 1'b1;
      bus.ld_issue_rd = rd;
      step();
   endtask

   initial begin
      int guard;
      logic [4:0] r;
      idle();
      bus.rs1_query = '0;
      bus.rs2_query = '0;
      model_reset();

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset rf_we", bus.rf_we, 1'b0);
      chk("reset index", bus.rf_rd_index, 5'd0);
      chk("reset data", bus.rf_rd_data, 32'd0);
      chk("reset mem_ready", bus.mem_ready, 1'b0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single ex write
      bus.ex_valid = 1'b1; bus.ex_rd = 5'd5; bus.ex_data = 32'hDEADBEEF;
      step();
      chk("ex5 we", bus.rf_we, 1'b1);
      chk("ex5 index", bus.rf_rd_index, 5'd5);
      chk("ex5 data", bus.rf_rd_data, 32'hDEADBEEF);
      idle();
      step();
      chk("ex5 pulse", bus.rf_we, 1'b0);

      // Load to x7 with busy tracking and bypass
      bus.rs1_query = 5'd7;
      issue(5'd7);
      idle();
      chk("x7 busy", bus.rs1_busy, 1'b1);
      bus.mem_valid = 1'b1; bus.mem_rd = 5'd7; bus.mem_data = 32'h12345678;
      step();
      chk("x7 we", bus.rf_we, 1'b1);
      chk("x7 data", bus.rf_rd_data, 32'h12345678);
      chk("x7 cleared", bus.rs1_busy, 1'b0);

      // ex and load collide: load buffered one cycle
      issue(5'd4);
      idle();
      bus.ex_valid = 1'b1; bus.ex_rd = 5'd3; bus.ex_data = 32'h33;
      bus.mem_valid = 1'b1; bus.mem_rd = 5'd4; bus.mem_data = 32'h44;
      step();
      chk("collide ex idx", bus.rf_rd_index, 5'd3);
      bus.ex_valid = 1'b0;
      step();
      chk("collide ld idx", bus.rf_rd_index, 5'd4);
      chk("collide ld data", bus.rf_rd_data, 32'h44);

      // ex held 4 cycles, 3 loads against a 2-deep buffer
      issue(5'd10);
      issue(5'd11);
      issue(5'd12);
      idle();
      for (int c = 0; c < 4; c++) begin
         bus.ex_valid = 1'b1; bus.ex_rd = 5'(c + 1); bus.ex_data = 32'(c + 100);
         present_mem();
         if (c == 2) begin
            #1;
            chk("starve ready low", bus.mem_ready, 1'b0);
         end
         step();
      end
      bus.ex_valid = 1'b0;
      guard = 0;
      while ((pending.size() > 0 || q_rd.size() > 0) && guard < 12) begin
         present_mem();
         step();
         guard++;
      end
      chk("starve drained", (guard < 12), 1'b1);
      bus.rs1_query = 5'd12;
      #1;
      chk("x12 retired", bus.rs1_busy, 1'b0);

      // Writes and loads to x0
      bus.ex_valid = 1'b1; bus.ex_rd = 5'd0; bus.ex_data = 32'h55;
      step();
      chk("x0 no we", bus.rf_we, 1'b0);
      bus.rs2_query = 5'd0;
      issue(5'd0);
      idle();
      step();
      chk("x0 never busy", bus.rs2_busy, 1'b0);

      // Reset with two buffered loads
      issue(5'd20);
      issue(5'd21);
      idle();
      bus.ex_valid = 1'b1; bus.ex_rd = 5'd1; bus.ex_data = 32'h1;
      bus.mem_valid = 1'b1; bus.mem_rd = 5'd20; bus.mem_data = 32'hA0;
      step();
      bus.ex_rd = 5'd2;
      bus.mem_valid = 1'b1; bus.mem_rd = 5'd21; bus.mem_data = 32'hA1;
      step();
      bus.ex_rd = 5'd3;
      bus.rs1_query = 5'd20;
      bus.rs2_query = 5'd21;
      #2;
      rst_n = 1'b0;
      #1;
      chk("midreset we", bus.rf_we, 1'b0);
      chk("midreset index", bus.rf_rd_index, 5'd0);
      chk("midreset data", bus.rf_rd_data, 32'd0);
      chk("midreset ready", bus.mem_ready, 1'b0);
      chk("midreset busy", {bus.rs1_busy, bus.rs2_busy}, 2'b00);
      idle();
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      repeat (4) step();

      // Random traffic against the queue model
      for (int i = 0; i < 400; i++) begin
         bus.ex_valid = ($urandom_range(1) == 1);
         r = 5'($urandom_range(31));
         bus.ex_rd   = mbusy[r] ? 5'd0 : r;
         bus.ex_data = $urandom;
         bus.ld_issue    = 1'b0;
         bus.ld_issue_rd = '0;
         r = 5'($urandom_range(31));
         if ($urandom_range(2) == 0 && !mbusy[r]) begin
            bus.ld_issue    = 1'b1;
            bus.ld_issue_rd = r;
         end
         if ($urandom_range(1) == 1) present_mem();
         bus.rs1_query = 5'($urandom_range(31));
         bus.rs2_query = 5'($urandom_range(31));
         step();
      end
      bus.ex_valid = 1'b0;
      bus.ld_issue = 1'b0;
      guard = 0;
      while ((pending.size() > 0 || q_rd.size() > 0 || bus.mem_valid) && guard < 80) begin
         present_mem();
         step();
         guard++;
      end
      chk("random drained", (guard < 80), 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
